// File: rtl/piano_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piano_pkg                                                            |
// | Shared pixel-bus widths, requester indices and arbiter FSM states.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package piano_pkg;

   localparam int X_W = 9;
   localparam int Y_W = 8;
   localparam int C_W = 3;

   localparam int REQ_RESET   = 0;
   localparam int REQ_DRAW    = 1;
   localparam int REQ_OVERLAY = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_pick                                                             |
// | One-hot winner select. PIXEL_ARB_ROUND_ROBIN_EN selects round-robin  |
// | starting at i_ptr; otherwise lowest index wins.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module arb_pick #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_win
);

`ifdef PIXEL_ARB_ROUND_ROBIN_EN
   logic w_found;
   int   w_idx;

   always_comb begin
      o_win   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // Rotate the search start to i_ptr, wrapping without a divider.
         w_idx = int'(i_ptr) + k;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
         if (!w_found && i_req[w_idx]) begin
            o_win[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end
`else
   logic w_unused_ptr;

   assign w_unused_ptr = ^i_ptr;
   // Isolate the lowest set bit.
   assign o_win = i_req & (~i_req + NUM_REQ'(1));
`endif

endmodule
`default_nettype wire

// File: rtl/pixel_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pixel_port_arbiter                                                   |
// | Burst-granular arbiter for the vga_adapter pixel write port.         |
// | Macro PIXEL_ARB_ROUND_ROBIN_EN enables round-robin arbitration.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pixel_port_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int X_W     = piano_pkg::X_W,
   parameter int Y_W     = piano_pkg::Y_W,
   parameter int C_W     = piano_pkg::C_W,
   localparam int OW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     px_valid,
   input  logic [NUM_REQ-1:0]     px_last,
   input  logic [NUM_REQ*X_W-1:0] px_x,
   input  logic [NUM_REQ*Y_W-1:0] px_y,
   input  logic [NUM_REQ*C_W-1:0] px_colour,
   output logic [NUM_REQ-1:0]     gnt,
   output logic                   busy,
   output logic [OW-1:0]          owner,
   output logic [X_W-1:0]         vga_x,
   output logic [Y_W-1:0]         vga_y,
   output logic [C_W-1:0]         vga_colour,
   output logic                   vga_plot
);
   import piano_pkg::*;

   arb_state_t         r_state, w_next;
   logic [NUM_REQ-1:0] w_win;
   logic [OW-1:0]      w_win_idx, w_ptr;
   logic               w_own_req, w_own_valid, w_own_last;
   logic               w_acc, w_grant, w_rel;

   assign w_own_req   = req[owner];
   assign w_own_valid = px_valid[owner];
   assign w_own_last  = px_last[owner];

   arb_pick #(.NUM_REQ(NUM_REQ), .PTR_W(OW)) u_pick (
      .i_req (req),
      .i_ptr (w_ptr),
      .o_win (w_win)
   );

   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (w_win[i]) w_win_idx = OW'(i);
   end

`ifdef PIXEL_ARB_ROUND_ROBIN_EN
   logic [OW-1:0] r_ptr;

   always_ff @(posedge clock) begin
      if (reset)
         r_ptr <= '0;
      else if (w_grant)
         r_ptr <= (w_win_idx == OW'(NUM_REQ-1)) ? '0 : w_win_idx + OW'(1);
   end
   assign w_ptr = r_ptr;
`else
   assign w_ptr = '0;
`endif

   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      w_rel   = 1'b0;
      // A last pixel still lands even if req drops in the same cycle.
      w_acc   = (r_state == ST_OWN) && w_own_valid && (w_own_req || w_own_last);
      case (r_state)
         ST_IDLE: if (|req) begin
            w_grant = 1'b1;
            w_next  = ST_OWN;
         end
         ST_OWN: if (!w_own_req || (w_acc && w_own_last)) begin
            w_rel  = 1'b1;
            w_next = ST_GAP;
         end
         ST_GAP:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         gnt        <= '0;
         busy       <= 1'b0;
         owner      <= '0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
      end else begin
         r_state  <= w_next;
         vga_plot <= w_acc;
         if (w_grant) begin
            gnt   <= w_win;
            busy  <= 1'b1;
            owner <= w_win_idx;
         end else if (w_rel) begin
            gnt   <= '0;
            busy  <= 1'b0;
         end
         if (w_acc) begin
            vga_x      <= px_x[int'(owner)*X_W +: X_W];
            vga_y      <= px_y[int'(owner)*Y_W +: Y_W];
            vga_colour <= px_colour[int'(owner)*C_W +: C_W];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pixel_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pixel_port_arbiter                                                |
// | Directed self-checking bench for pixel_port_arbiter.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pixel_port_arbiter;

   localparam int N   = 3;
   localparam int X_W = 9;
   localparam int Y_W = 8;
   localparam int C_W = 3;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   req, px_valid, px_last;
   logic [X_W-1:0] x_a [N];
   logic [Y_W-1:0] y_a [N];
   logic [C_W-1:0] c_a [N];
   logic [N*X_W-1:0] px_x;
   logic [N*Y_W-1:0] px_y;
   logic [N*C_W-1:0] px_colour;
   logic [N-1:0]   gnt;
   logic           busy;
   logic [1:0]     owner;
   logic [X_W-1:0] vga_x;
   logic [Y_W-1:0] vga_y;
   logic [C_W-1:0] vga_colour;
   logic           vga_plot;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   assign px_x      = {x_a[2], x_a[1], x_a[0]};
   assign px_y      = {y_a[2], y_a[1], y_a[0]};
   assign px_colour = {c_a[2], c_a[1], c_a[0]};

   pixel_port_arbiter #(.NUM_REQ(N), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut (
      .clock(clock), .reset(reset), .req(req), .px_valid(px_valid),
      .px_last(px_last), .px_x(px_x), .px_y(px_y), .px_colour(px_colour),
      .gnt(gnt), .busy(busy), .owner(owner), .vga_x(vga_x), .vga_y(vga_y),
      .vga_colour(vga_colour), .vga_plot(vga_plot)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_px(input int i, input int x, input int y, input int c);
      x_a[i] = X_W'(x);
      y_a[i] = Y_W'(y);
      c_a[i] = C_W'(c);
   endtask

   initial begin
      reset = 1'b1; req = '0; px_valid = '0; px_last = '0;
      for (int i = 0; i < N; i++) set_px(i, 0, 0, 0);
      step(); step();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_owner", 32'(owner), 0);
      check("rst_pix", {vga_plot, 7'(vga_x), 8'(vga_y), 5'(vga_colour)}, 0);
      reset = 1'b0;

      // Single burst by requester 1; requester 2 drives x=300 as a non-owner
      req = 3'b010;
      step();
      check("burst_gnt", 32'(gnt), 32'b010);
      check("burst_busy", 32'(busy), 1);
      check("burst_owner", 32'(owner), 1);
      px_valid = 3'b110; set_px(1, 10, 20, 5); set_px(2, 300, 99, 7);
      step();
      check("p0", {vga_plot, 7'(0), 9'(vga_x), 8'(vga_y), 3'(vga_colour)}, {1'b1, 7'(0), 9'd10, 8'd20, 3'd5});
      set_px(1, 11, 20, 5);
      step();
      check("p1", {vga_plot, 7'(0), 9'(vga_x), 8'(vga_y), 3'(vga_colour)}, {1'b1, 7'(0), 9'd11, 8'd20, 3'd5});
      set_px(1, 12, 20, 5); px_last = 3'b010;
      step();
      check("p2", {vga_plot, 7'(0), 9'(vga_x), 8'(vga_y), 3'(vga_colour)}, {1'b1, 7'(0), 9'd12, 8'd20, 3'd5});
      check("p2_gnt", 32'(gnt), 0);
      check("p2_busy", 32'(busy), 0);
      req = '0; px_valid = 3'b100; px_last = '0;
      step();
      check("gap_noplot", 32'(vga_plot), 0);
      check("gap_hold_x", 32'(vga_x), 12);
      check("owner_kept", 32'(owner), 1);
      px_valid = '0;

      // Contention: 0 and 1 together, 0 wins in both modes from this state
      req = 3'b011;
      step();
      check("cont_gnt0", 32'(gnt), 32'b001);
      px_valid = 3'b001; px_last = 3'b001; set_px(0, 5, 6, 1);
      step();
      check("cont_rel", 32'(gnt), 0);
      check("cont_plot", {vga_plot, 7'(0), 9'(vga_x), 8'(vga_y), 3'(vga_colour)}, {1'b1, 7'(0), 9'd5, 8'd6, 3'd1});
      req = 3'b010; px_valid = '0; px_last = '0;
      step();
      check("cont_gap", 32'(gnt), 0);
      step();
      check("cont_gnt1", 32'(gnt), 32'b010);
      check("cont_owner1", 32'(owner), 1);

      // Abort by owner 1
      px_valid = 3'b010; set_px(1, 20, 30, 2);
      step();
      check("ab_plot", 32'(vga_x), 20);
      req = '0; set_px(1, 21, 30, 2);
      step();
      check("ab_gnt", 32'(gnt), 0);
      check("ab_busy", 32'(busy), 0);
      check("ab_noplot", 32'(vga_plot), 0);
      check("ab_hold_x", 32'(vga_x), 20);
      px_valid = '0; req = 3'b100;
      step();
      check("ab_gap", 32'(gnt), 0);
      step();
      check("ab_regrant", 32'(gnt), 32'b100);

      // Reset mid-burst with a pixel in flight
      px_valid = 3'b100; set_px(2, 7, 8, 2); reset = 1'b1;
      step();
      check("mr_gnt", 32'(gnt), 0);
      check("mr_busy", 32'(busy), 0);
      check("mr_owner", 32'(owner), 0);
      check("mr_pix", {vga_plot, 7'(vga_x), 8'(vga_y), 5'(vga_colour)}, 0);
      reset = 1'b0; px_valid = '0;
      step();
      check("mr_regrant", 32'(gnt), 32'b100);
      check("mr_owner2", 32'(owner), 2);
      req = '0;
      step(); step();

`ifdef PIXEL_ARB_ROUND_ROBIN_EN
      // Pointer is 0 after reset and the grant to 2; expect 0,1,2,0
      req = 3'b111; px_valid = 3'b111; px_last = 3'b111;
      step(); check("rr_g0", 32'(gnt), 32'b001);
      step(); check("rr_r0", 32'(gnt), 0);
      step(); check("rr_d0", 32'(gnt), 0);
      step(); check("rr_g1", 32'(gnt), 32'b010);
      step(); check("rr_r1", 32'(gnt), 0);
      step(); check("rr_d1", 32'(gnt), 0);
      step(); check("rr_g2", 32'(gnt), 32'b100);
      step(); check("rr_r2", 32'(gnt), 0);
      step(); check("rr_d2", 32'(gnt), 0);
      step(); check("rr_g3", 32'(gnt), 32'b001);
      req = '0; px_valid = '0; px_last = '0;
      step(); step();
`else
      // Fixed priority: 0 keeps winning while it requests
      req = 3'b111; px_valid = 3'b001; px_last = 3'b001;
      step(); check("fp_g0", 32'(gnt), 32'b001);
      step(); step();
      step(); check("fp_g0_again", 32'(gnt), 32'b001);
      req = '0; px_valid = '0; px_last = '0;
      step(); step();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
